// File: rtl/pll_reset_sequencer_if.sv
// Bundles the PLL lock input and the staged reset outputs of the sequencer.
// Latency: none (plain wires). Backpressure: none; reset outputs are level signals.
// Ports: locked (raw PLL lock), rst_n_out[STAGES], ready, lock_loss_count[8], state[2].
interface pll_reset_sequencer_if #(
  parameter int STAGES = 3
);
  logic              locked;
  logic [STAGES-1:0] rst_n_out;
  logic              ready;
  logic [7:0]        lock_loss_count;
  logic [1:0]        state;

  // master: the sequencer itself; slave: the PLL/consumer side.
  modport master (
    input  locked,
    output rst_n_out,
    output ready,
    output lock_loss_count,
    output state
  );

  modport slave (
    output locked,
    input  rst_n_out,
    input  ready,
    input  lock_loss_count,
    input  state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, releases reset domains one by one, re-asserts all on confirmed lock loss.
// Latency: bit 0 released LOCK_CYCLES+3 edges after locked is first sampled high; loss seen GLITCH_CYCLES+2 edges after drop.
// Backpressure: none; all outputs are registered levels, consumers simply observe them.
// Ports: clk, resetn (sync, active-low), bus (master modport: locked in; rst_n_out, ready,
//        lock_loss_count, state out).
module pll_reset_sequencer #(
  parameter int LOCK_CYCLES   = 1024,
  parameter int STAGES        = 3,
  parameter int STAGE_GAP     = 16,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  pll_reset_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [15:0] QUAL_LAST   = 16'(LOCK_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST    = 8'(STAGE_GAP - 1);
  localparam logic [7:0]  GLITCH_LAST = 8'(GLITCH_CYCLES - 1);

  // Two-flop synchroniser for the asynchronous lock flag.
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  state_e            state_q, state_d;
  logic [15:0]       qual_cnt_q, qual_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [2:0]        stage_idx_q, stage_idx_d;  // index of the last released bit
  logic [7:0]        glitch_cnt_q, glitch_cnt_d;
  logic [STAGES-1:0] rst_n_q, rst_n_d;
  logic              ready_q, ready_d;
  logic [7:0]        loss_cnt_q, loss_cnt_d;

  always_comb begin
    s1_d         = bus.locked;
    s2_d         = s1_q;
    state_d      = state_q;
    qual_cnt_d   = qual_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    stage_idx_d  = stage_idx_q;
    glitch_cnt_d = glitch_cnt_q;
    rst_n_d      = rst_n_q;
    ready_d      = ready_q;
    loss_cnt_d   = loss_cnt_q;

    unique case (state_q)
      WAIT_LOCK: begin
        rst_n_d      = '0;
        ready_d      = 1'b0;
        glitch_cnt_d = '0;
        if (s2_q) begin
          state_d    = STABLE;
          qual_cnt_d = '0;
        end
      end

      STABLE: begin
        // A drop here just restarts qualification; it is not a lock loss.
        if (!s2_q) begin
          state_d = WAIT_LOCK;
        end else if (qual_cnt_q == QUAL_LAST) begin
          rst_n_d[0]   = 1'b1;
          gap_cnt_d    = '0;
          stage_idx_d  = '0;
          glitch_cnt_d = '0;
          if (STAGES == 1) begin
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          qual_cnt_d = qual_cnt_q + 16'd1;
        end
      end

      RELEASE, RUN: begin
        glitch_cnt_d = s2_q ? 8'd0 : glitch_cnt_q + 8'd1;

        // Release keeps progressing through unconfirmed glitches.
        if (state_q == RELEASE) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d   = '0;
            stage_idx_d = stage_idx_q + 3'd1;
            for (int i = 0; i < STAGES; i++) begin
              if (i == int'(stage_idx_q) + 1) rst_n_d[i] = 1'b1;
            end
            if (int'(stage_idx_q) + 2 == STAGES) begin
              ready_d = 1'b1;
              state_d = RUN;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end

        // Confirmed loss overrides any release happening on the same edge.
        if (!s2_q && (glitch_cnt_q == GLITCH_LAST)) begin
          state_d      = WAIT_LOCK;
          rst_n_d      = '0;
          ready_d      = 1'b0;
          glitch_cnt_d = '0;
          if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
        end
      end

      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      state_q      <= WAIT_LOCK;
      qual_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      stage_idx_q  <= '0;
      glitch_cnt_q <= '0;
      rst_n_q      <= '0;
      ready_q      <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      state_q      <= state_d;
      qual_cnt_q   <= qual_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      stage_idx_q  <= stage_idx_d;
      glitch_cnt_q <= glitch_cnt_d;
      rst_n_q      <= rst_n_d;
      ready_q      <= ready_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign bus.rst_n_out       = rst_n_q;
  assign bus.ready           = ready_q;
  assign bus.lock_loss_count = loss_cnt_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: event scoreboard fed by a timestamp-based reference model.
// Latency: n/a. Backpressure: n/a.
// Ports: none (top-level bench).
module tb_pll_reset_sequencer;
  localparam int L   = 8;
  localparam int S   = 3;
  localparam int GAP = 4;
  localparam int G   = 4;
  localparam int W   = S + 1 + 8 + 2;

  typedef struct {
    int           edge_n;
    logic [W-1:0] val;
  } exp_t;

  logic clk;
  logic resetn;

  pll_reset_sequencer_if #(.STAGES(S)) bus ();

  pll_reset_sequencer #(
    .LOCK_CYCLES  (L),
    .STAGES       (S),
    .STAGE_GAP    (GAP),
    .GLITCH_CYCLES(G)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks   = 0;
  int           errors   = 0;
  int           edge_cnt = 0;
  exp_t         sb_q[$];
  logic [W-1:0] last_dv  = '0;

  // Reference model, expressed as timestamps of phase changes rather than counters.
  logic         m_s1 = 1'b0, m_s2 = 1'b0;
  int           m_phase = 0;     // 0 idle, 1 qualifying, 2 released
  int           m_tstart = 0;    // edge at which qualification started
  int           m_r0 = 0;        // edge at which bit 0 was released
  int           m_zrun = 0;      // consecutive unlocked cycles seen since release
  int           m_loss = 0;
  logic [W-1:0] m_prev = '0;

  task automatic model_edge(input int t, input logic lk, input logic rs);
    logic         seen;
    logic [S-1:0] r;
    logic         rdy;
    logic [1:0]   st;
    logic [W-1:0] v;
    exp_t         e;
    seen = m_s2;
    if (!rs) begin
      m_phase = 0; m_zrun = 0; m_loss = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      if (m_phase == 0) begin
        if (seen) begin m_phase = 1; m_tstart = t; end
      end else if (m_phase == 1) begin
        if (!seen) m_phase = 0;
        else if (t - m_tstart == L) begin m_phase = 2; m_r0 = t; m_zrun = 0; end
      end else begin
        m_zrun = seen ? 0 : m_zrun + 1;
        if (m_zrun == G) begin
          m_phase = 0;
          m_zrun  = 0;
          if (m_loss < 255) m_loss = m_loss + 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = lk;
    end
    r = '0; rdy = 1'b0; st = 2'd0;
    if (m_phase == 1) st = 2'd1;
    else if (m_phase == 2) begin
      for (int k = 0; k < S; k++) if (t >= m_r0 + k * GAP) r[k] = 1'b1;
      rdy = &r;
      st  = rdy ? 2'd3 : 2'd2;
    end
    v = {r, rdy, 8'(m_loss), st};
    if ((v != m_prev) || !rs) begin
      e.edge_n = t;
      e.val    = v;
      sb_q.push_back(e);
    end
    m_prev = v;
  endtask

  // Drive inputs for the next edge, record expectations, then advance one edge.
  task automatic step(input logic lk, input logic rs);
    bus.locked = lk;
    resetn     = rs;
    model_edge(edge_cnt + 1, lk, rs);
    @(posedge clk);
    edge_cnt++;
    #2;
  endtask

  task automatic hold(input logic lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b1);
  endtask

  // Monitor: pops on every output change or whenever an expectation is due this edge.
  always @(negedge clk) begin
    logic [W-1:0] dv;
    exp_t         e;
    dv = {bus.rst_n_out, bus.ready, bus.lock_loss_count, bus.state};
    if (edge_cnt > 0) begin
      if ((dv !== last_dv) || ((sb_q.size() > 0) && (sb_q[0].edge_n == edge_cnt))) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected edge=%0d got=%h required=none", edge_cnt, dv);
        end else begin
          e = sb_q.pop_front();
          if ((e.edge_n != edge_cnt) || (e.val !== dv)) begin
            errors++;
            $display("FAIL sb_event edge=%0d got=%h required=%h@edge%0d",
                     edge_cnt, dv, e.val, e.edge_n);
          end
        end
      end
      last_dv = dv;
    end
  end

  initial begin
    bus.locked = 1'b0;
    resetn     = 1'b0;

    // Reset held with lock present, then a full release sequence.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    hold(1'b1, 24);

    // Short glitch in RUN: filtered.
    hold(1'b0, 3);
    hold(1'b1, 8);

    // Long drop in RUN: confirmed loss, then resequence.
    hold(1'b0, 10);
    hold(1'b1, 26);

    // Loss, then a one-cycle drop mid-qualification.
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 1);
    hold(1'b1, 26);

    // One-cycle reset between release of bit 1 and bit 2.
    hold(1'b0, 8);
    hold(1'b1, 17);
    step(1'b1, 1'b0);
    hold(1'b1, 26);

    // Drive enough confirmed losses to saturate the counter.
    for (int n = 0; n < 300; n++) begin
      hold(1'b1, 14);
      hold(1'b0, 8);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.lock_loss_count !== 8'd255) begin
      errors++;
      $display("FAIL loss_saturate got=%0d required=255", bus.lock_loss_count);
    end

    // Randomised lock behaviour with occasional reset pulses.
    for (int seg = 0; seg < 120; seg++) begin
      int   n;
      logic lv;
      lv = (seg % 2 == 0);
      n  = lv ? $urandom_range(30, 1) : $urandom_range(8, 1);
      for (int i = 0; i < n; i++) step(lv, ($urandom_range(99, 0) != 0));
    end
    hold(1'b1, 30);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d pending required=0", sb_q.size());
    end
    checks++;
    if (bus.lock_loss_count !== 8'(m_loss)) begin
      errors++;
      $display("FAIL final_loss_count got=%0d required=%0d", bus.lock_loss_count, m_loss);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumes the `locked` flag of the 64 MHz system PLL and produces clean, staged, synchronous active-low resets for the core logic clocked by that PLL. It synchronises `locked`, requires it to stay high for a programmable qualification period, then releases reset domains one by one with a fixed gap between them. It re-asserts all resets on a confirmed loss of lock and counts lock-loss events for debug.

## Interface
- `LOCK_CYCLES`, 1024: consecutive synchronised-locked cycles required before release; legal range 1..65535.
- `STAGES`, 3: number of reset domains; legal range 1..8.
- `STAGE_GAP`, 16: cycles between successive domain releases; legal range 1..255.
- `GLITCH_CYCLES`, 4: consecutive synchronised-unlocked cycles that confirm a lock loss; legal range 1..255.

Ports:
- `clk` input 1: PLL output clock (64.062 MHz); all logic runs on its rising edge.
- `resetn` input 1: one clock; reset is synchronous and active-low.
- `locked` input 1: raw PLL lock, asynchronous to `clk`.
- `rst_n_out` output STAGES: per-domain active-low reset, released in order from bit 0 to bit STAGES-1.
- `ready` output 1: high when every domain is released.
- `lock_loss_count` output 8: number of confirmed lock losses, saturating.
- `state` output 2: FSM state for debug.

## Operation
- `locked` passes through a 2-flop synchroniser (`s1`, `s2`). All FSM decisions use `s2` only.
- States and encoding: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3.
- WAIT_LOCK: all `rst_n_out`=0 and `ready`=0. When `s2`=1, go to STABLE and set the qualification counter (16-bit) to 0.
- STABLE: if `s2`=0, return to WAIT_LOCK. This does not count as a lock loss.
  - Otherwise increment the counter.
  - On the edge where the counter equals LOCK_CYCLES-1, go to RELEASE, set `rst_n_out[0]`=1, and clear the stage index and gap counter.
- RELEASE: the gap counter increments each cycle.
  - When it reaches STAGE_GAP-1, the next `rst_n_out` bit goes high and the gap counter clears.
  - The edge that releases bit STAGES-1 also sets `ready`=1 and enters RUN.
  - If STAGES=1, STABLE goes directly to RUN, and `rst_n_out[0]` and `ready` rise on the same edge.
- RELEASE and RUN, lock-loss detection:
  - The glitch counter increments on each `s2`=0 cycle and clears on any `s2`=1 cycle.
  - When it reaches GLITCH_CYCLES, a loss is confirmed. On that edge: all `rst_n_out`=0, `ready`=0, state goes to WAIT_LOCK, and `lock_loss_count` increments, saturating at 255.
  - Release progress continues during unconfirmed glitches.
- Released bits stay high until a confirmed loss or `resetn`. They never drop individually.
- `resetn`=0 (any state, mid-release included), on the next edge: `s1`=`s2`=0, all counters 0, state WAIT_LOCK, `rst_n_out`=0, `ready`=0, `lock_loss_count`=0.

## Timing
- Reset values: `rst_n_out`=0, `ready`=0, `lock_loss_count`=0, `state`=0.
- All outputs are registered. No combinational path from any input to any output.
- Edge numbering: edge 1 is the first rising edge that samples `locked`=1, with `locked` held high.
  - `state`=STABLE after edge 3.
  - `rst_n_out[0]`=1 after edge LOCK_CYCLES+3.
  - `rst_n_out[k]`=1 after edge LOCK_CYCLES+3+k·STAGE_GAP.
  - `ready` rises together with `rst_n_out[STAGES-1]`.
- Lock-loss latency: for `locked` low from edge 1, outputs drop after edge GLITCH_CYCLES+2.
- `locked` low pulses shorter than GLITCH_CYCLES sampled cycles, measured after synchronisation, have no effect in RELEASE or RUN.
- A single-cycle `s2` drop in STABLE restarts qualification from WAIT_LOCK. The next `s2`=1 cycle re-enters STABLE with the counter at 0.
- If a confirmed loss and `resetn`=0 occur on the same edge, reset wins and `lock_loss_count`=0.

## Test plan
Test parameters: LOCK_CYCLES=8, STAGES=3, STAGE_GAP=4, GLITCH_CYCLES=4.
1. Hold `resetn`=0 for 5 cycles with `locked`=1, then release. Expect all outputs 0 during reset. After `resetn` rises, `rst_n_out`=001 after edge 11, 011 after edge 15, 111 with `ready`=1 after edge 19, and `state`=3.
2. In RUN, drive `locked` low for 3 cycles. Expect no output change and `lock_loss_count`=0.
3. In RUN, drive `locked` low for 10 cycles. Expect `rst_n_out`=000, `ready`=0 and `state`=0 after edge 6, and `lock_loss_count`=1. After `locked` returns, the full release sequence repeats.
4. In STABLE at counter value 5, drive `locked` low for 1 cycle. Expect a return to WAIT_LOCK, `lock_loss_count` unchanged, and `rst_n_out[0]` rising 11 edges after `locked` is sampled high again.
5. Pulse `resetn` low for 1 cycle between the releases of bit 1 and bit 2. Expect all outputs 0 on the next edge, then a full resequence.
6. Force 300 confirmed lock losses. Expect `lock_loss_count` to hold at 255.
